alu_serie: RTL and testbench
============================

Name: alu_serie

Overview:
- Parametrised, multi-cycle successor to the 4-bit ripple adder/logic unit.
- Processes a WIDTH-bit operation DIGIT bits per clock, LSB digit first.
- Carries between digits in a register, so one DIGIT-wide cell slice is reused over WIDTH/DIGIT cycles.
- Sits between the register file operand latches and the datapath result bus; controlled by a start/done handshake.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. STEPS = WIDTH/DIGIT.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the FSM is in IDLE or DONE.
- OP1  input  WIDTH  first operand; latched on an accepted start.
- OP2  input  WIDTH  second operand; latched on an accepted start.
- ALUOp  input  2  operation select; latched on an accepted start.
- L  input  1  0 = arithmetic, 1 = logic; latched on an accepted start.
- Cin0  input  1  carry into digit 0; latched on an accepted start.
- R  output  WIDTH  result; held stable from done until the next accepted start.
- cout  output  1  carry out of the MSB; 0 for logic ops.
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB); 0 for logic ops.
- zero  output  1  1 when the final R == 0.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when R and the flags become valid.

Behaviour:
- Reset (sync, active-high): state = IDLE; R, cout, ovf, zero, busy, done = 0; digit counter and carry register = 0. Reset overrides start and aborts any operation in progress; the partial R is discarded, not kept.
- Operation set:
  - L=0, ALUOp=00: OP1 + OP2 + Cin0
  - L=0, ALUOp=01: OP1 + ~OP2 + Cin0 (subtract when Cin0=1)
  - L=0, ALUOp=10: OP1 + Cin0
  - L=0, ALUOp=11: OP2 + Cin0
  - L=1, ALUOp=00: AND
  - L=1, ALUOp=01: OR
  - L=1, ALUOp=10: XOR
  - L=1, ALUOp=11: ~OP1
  - Logic ops: cout = 0, ovf = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start=1 → RUN. Latch the operands, ALUOp, L and Cin0 into the carry register; digit counter = 0.
  - RUN, each cycle: compute digit k = counter from the latched operands and the carry register. Write bits [k*DIGIT +: DIGIT] of R. Update the carry register with the digit's carry out; counter++.
  - RUN, on the cycle with k = STEPS-1 → DONE. Capture cout. ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. zero from the complete R.
  - DONE: done = 1 for exactly this cycle. start=1 → RUN (back-to-back, latching new operands). Otherwise → IDLE.
- Latency: start sampled high at edge t (IDLE/DONE). busy = 1 during cycles t+1 … t+STEPS. done = 1 during cycle t+STEPS+1. Results are visible from that same cycle.
- start while busy=1: ignored; no effect on latched operands or timing.
- Input changes after acceptance: OP1, OP2, ALUOp, L and Cin0 may change freely after an accepted start; only the latched copies are used.
- R during RUN: R updates digit by digit and is not valid until done. cout, ovf and zero hold their previous values until the DONE transition.
- DIGIT = WIDTH: STEPS = 1; busy for one cycle; done at t+2.
- DIGIT = 1: pure bit-serial operation; STEPS = WIDTH.

Test Plan (WIDTH=16, DIGIT=4, STEPS=4):
- Add, L=0, ALUOp=00, Cin0=0, 0x00FF + 0x0001 → R=0x0100, cout=0, ovf=0, zero=0. busy high in cycles t+1..t+4; done pulse at t+5 only.
- Subtract, ALUOp=01, Cin0=1, 0x0005 − 0x0007 → R=0xFFFE, cout=0, ovf=0. Then 0x0007 − 0x0005 → R=0x0002, cout=1.
- Overflow/wrap: 0x7FFF + 0x0001 → R=0x8000, ovf=1, cout=0. 0xFFFF + 0x0001 → R=0x0000, cout=1, zero=1, ovf=0.
- Logic, L=1: ALUOp=10, 0xA5A5 ^ 0xFFFF → R=0x5A5A, cout=0, ovf=0. ALUOp=11, OP1=0xFFFF → R=0x0000, zero=1.
- Handshake:
  - start held high with changing OP1 during RUN → ignored; result matches the first operands.
  - start asserted in the DONE cycle → new RUN begins next cycle, no IDLE gap; R holds the old result until overwritten.
- Reset mid-op: assert reset at t+2 of an add → next cycle all outputs 0, FSM in IDLE, no done pulse. A fresh start then completes normally.

Source files
------------

// File: rtl/alu_serie.sv
// Digit-serial adder/logic unit: one DIGIT-wide cell slice is reused over WIDTH/DIGIT cycles,
// LSB digit first, with the inter-digit carry held in a register. Start/done handshake.
module alu_serie #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] OP1,
  input  logic [WIDTH-1:0] OP2,
  input  logic [1:0]       ALUOp,
  input  logic             L,
  input  logic             Cin0,
  output logic [WIDTH-1:0] R,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] op1_sh;
  logic [WIDTH-1:0] op2_sh;
  logic [1:0]       op_lat;
  logic             l_lat;
  logic             carry;
  logic [CW-1:0]    count;

  logic [DIGIT-1:0] x, y, a, b, sum, logic_res, digit_res;
  logic [DIGIT:0]   chain;
  logic [WIDTH-1:0] r_next;
  logic             last;

  // Latched operands shift right one digit per step, so the live digit is always the low slice.
  assign x = op1_sh[DIGIT-1:0];
  assign y = op2_sh[DIGIT-1:0];

  always_comb begin
    a = x;
    b = y;
    unique case (op_lat)
      2'b00: begin a = x;  b = y;  end
      2'b01: begin a = x;  b = ~y; end
      2'b10: begin a = x;  b = '0; end
      default: begin a = '0; b = y; end
    endcase
  end

  assign chain[0] = carry;
  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_cell
      assign sum[gi]       = a[gi] ^ b[gi] ^ chain[gi];
      assign chain[gi + 1] = (a[gi] & b[gi]) | (chain[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  always_comb begin
    logic_res = '0;
    unique case (op_lat)
      2'b00:   logic_res = x & y;
      2'b01:   logic_res = x | y;
      2'b10:   logic_res = x ^ y;
      default: logic_res = ~x;
    endcase
  end

  assign digit_res = l_lat ? logic_res : sum;
  assign last      = (count == CW'(STEPS - 1));

  // Result with the current digit merged in; also used for the zero flag on the final step.
  always_comb begin
    r_next = R;
    r_next[int'(count) * DIGIT +: DIGIT] = digit_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op1_sh <= '0;
      op2_sh <= '0;
      op_lat <= '0;
      l_lat  <= 1'b0;
      carry  <= 1'b0;
      count  <= '0;
      R      <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op1_sh <= OP1;
            op2_sh <= OP2;
            op_lat <= ALUOp;
            l_lat  <= L;
            carry  <= Cin0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          R      <= r_next;
          carry  <= chain[DIGIT];
          count  <= count + CW'(1);
          op1_sh <= op1_sh >> DIGIT;
          op2_sh <= op2_sh >> DIGIT;
          if (last) begin
            // chain[DIGIT-1] is the carry into bit WIDTH-1 on the final digit.
            cout  <= l_lat ? 1'b0 : chain[DIGIT];
            ovf   <= l_lat ? 1'b0 : (chain[DIGIT] ^ chain[DIGIT-1]);
            zero  <= (r_next == '0);
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serie.sv
// Scoreboard bench for alu_serie (WIDTH=16, DIGIT=4): stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_serie;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int STEPS = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             reset, start, L, Cin0;
  logic [WIDTH-1:0] OP1, OP2;
  logic [1:0]       ALUOp;
  logic [WIDTH-1:0] R;
  logic             cout, ovf, zero, busy, done;

  typedef struct {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;
    logic             z;
  } exp_t;

  exp_t             exp_q[$];
  int               asserts = 0;
  int               fails   = 0;
  int               txn     = 0;
  logic [WIDTH-1:0] last_r  = '0;

  alu_serie #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .OP1(OP1), .OP2(OP2), .ALUOp(ALUOp), .L(L), .Cin0(Cin0),
    .R(R), .cout(cout), .ovf(ovf), .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("done_spurious", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d: R=%h cout=%b ovf=%b zero=%b (want R=%h cout=%b ovf=%b zero=%b)",
                 txn, R, cout, ovf, zero, e.r, e.c, e.v, e.z);
        check("R", 32'(R), 32'(e.r));
        check("cout", 32'(cout), 32'(e.c));
        check("ovf", 32'(ovf), 32'(e.v));
        check("zero", 32'(zero), 32'(e.z));
      end
    end
  end

  // Issues one operation and checks busy/done timing. b2b: called during a DONE cycle.
  // hold: keep start high through RUN while OP1 changes underneath.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [1:0] op, input logic l, input logic c,
                        input logic [WIDTH-1:0] er, input logic ec, input logic ev,
                        input logic ez, input bit hold, input bit b2b);
    exp_t e;
    if (!b2b) @(negedge clk);
    OP1 = a; OP2 = b; ALUOp = op; L = l; Cin0 = c; start = 1'b1;
    e.r = er; e.c = ec; e.v = ev; e.z = ez;
    exp_q.push_back(e);
    for (int i = 0; i < STEPS; i++) begin
      @(negedge clk);
      start = hold && (i < STEPS - 1);
      if (hold) begin
        OP1  = WIDTH'($urandom);
        Cin0 = ~Cin0;
      end
      if (b2b && i == 0) check("b2b_R_held", 32'(R), 32'(last_r));
      check("busy_run", 32'(busy), 32'd1);
      check("done_run", 32'(done), 32'd0);
    end
    @(negedge clk);
    check("busy_done", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    last_r = er;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; OP1 = '0; OP2 = '0; ALUOp = '0; L = 1'b0; Cin0 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_R", 32'(R), 32'd0);
    check("rst_flags", 32'({cout, ovf, zero, busy, done}), 32'd0);
    reset = 1'b0;

    run_op(16'h00FF, 16'h0001, 2'b00, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(16'h0005, 16'h0007, 2'b01, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(16'h0007, 16'h0005, 2'b01, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 0, 0);
    run_op(16'h7FFF, 16'h0001, 2'b00, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0, 0);

    // Abort an add with reset during its second RUN cycle.
    @(negedge clk);
    OP1 = 16'h0001; OP2 = 16'h0001; ALUOp = 2'b00; L = 1'b0; Cin0 = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_R", 32'(R), 32'd0);
    check("midrst_flags", 32'({cout, ovf, zero, busy, done}), 32'd0);
    for (int i = 0; i < STEPS + 2; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 32'd0);
    end
    last_r = '0;

    run_op(16'h4000, 16'h4000, 2'b00, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0, 0);
    run_op(16'hFFFF, 16'h0001, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 0);
    run_op(16'hA5A5, 16'hFFFF, 2'b10, 1'b1, 1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(16'hFFFF, 16'h1234, 2'b11, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 0);
    run_op(16'hF0F0, 16'h3C3C, 2'b00, 1'b1, 1'b0, 16'h3030, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(16'h1200, 16'h0034, 2'b01, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(16'h1233, 16'hFFFF, 2'b10, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(16'h0000, 16'hFFFF, 2'b11, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(16'h1111, 16'h2222, 2'b00, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1, 0);

    // Back-to-back: second start lands in the DONE cycle of the first.
    run_op(16'h1000, 16'h0234, 2'b00, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 0, 0);
    run_op(16'h1234, 16'h0234, 2'b01, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b0, 0, 1);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(txn), 32'd15);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
